// File: rtl/axis_frame_guard_if.sv
// AXI-stream beat bundle (data, valid/ready handshake, end-of-frame, bad-frame flag)
// shared by the ingress and egress sides of axis_frame_guard.
interface axis_frame_guard_if #(
   parameter int unsigned DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] tdata;
   logic                  tvalid;
   logic                  tready;
   logic                  tlast;
   logic                  tuser;

   modport master (
      output tdata,
      output tvalid,
      input  tready,
      output tlast,
      output tuser
   );

   modport slave (
      input  tdata,
      input  tvalid,
      output tready,
      input  tlast,
      input  tuser
   );
endinterface

// File: rtl/axis_frame_guard.sv
// Frame-length guard ahead of the frame FIFO: truncates over-long frames (tlast+tuser forced)
// and drops their tail. Optional runt flagging via `AXIS_FRAME_GUARD_RUNT_EN.
module axis_frame_guard #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned MAX_LEN    = 1522,
   parameter int unsigned MIN_LEN    = 64,
   parameter int unsigned LEN_WIDTH  = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   axis_frame_guard_if.slave         input_axis,
   axis_frame_guard_if.master        output_axis,
   output logic                      trunc_frame
);

   typedef enum logic {
      ST_PASS    = 1'b0,
      ST_DISCARD = 1'b1
   } state_t;

   // Elaboration-time parameter sanity
   if (MAX_LEN < 1 || 64'(MAX_LEN) >= (64'd1 << LEN_WIDTH)) begin : g_bad_max_len
      $error("axis_frame_guard: MAX_LEN must be in 1 .. 2**LEN_WIDTH-1");
   end
   if (MIN_LEN < 1 || MIN_LEN > MAX_LEN) begin : g_bad_min_len
      $error("axis_frame_guard: MIN_LEN must be in 1 .. MAX_LEN");
   end

   state_t                state;
   logic [LEN_WIDTH-1:0]  cnt;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_valid;
   logic                  out_last;
   logic                  out_user;

   logic [LEN_WIDTH-1:0]  cnt_inc_c;
   logic                  at_max_c;
   logic                  in_ready_c;
   logic                  accept_c;
   logic                  drain_c;
   logic                  runt_c;

   // Handshake and length decode
   always_comb begin
      cnt_inc_c  = cnt + LEN_WIDTH'(1);
      at_max_c   = (cnt_inc_c == LEN_WIDTH'(MAX_LEN));
      in_ready_c = (state == ST_DISCARD) || !out_valid || output_axis.tready;
      accept_c   = input_axis.tvalid && in_ready_c;
      drain_c    = out_valid && output_axis.tready;
   end

`ifdef AXIS_FRAME_GUARD_RUNT_EN
   assign runt_c = (cnt_inc_c < LEN_WIDTH'(MIN_LEN));
`else
   assign runt_c = 1'b0;
`endif

   assign input_axis.tready  = in_ready_c;
   assign output_axis.tdata  = out_data;
   assign output_axis.tvalid = out_valid;
   assign output_axis.tlast  = out_last;
   assign output_axis.tuser  = out_user;

   // State, beat counter and the single output register stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_PASS;
         cnt         <= '0;
         out_valid   <= 1'b0;
         out_data    <= '0;
         out_last    <= 1'b0;
         out_user    <= 1'b0;
         trunc_frame <= 1'b0;
      end else begin
         trunc_frame <= 1'b0;
         if (drain_c) begin
            out_valid <= 1'b0;
         end
         if (accept_c) begin
            case (state)
               ST_PASS: begin
                  out_valid <= 1'b1;
                  out_data  <= input_axis.tdata;
                  if (input_axis.tlast) begin
                     out_last <= 1'b1;
                     out_user <= input_axis.tuser | runt_c;
                     cnt      <= '0;
                  end else if (at_max_c) begin
                     // Frame hit the limit without tlast: close it as bad, drop the tail
                     out_last    <= 1'b1;
                     out_user    <= 1'b1;
                     cnt         <= '0;
                     state       <= ST_DISCARD;
                     trunc_frame <= 1'b1;
                  end else begin
                     out_last <= 1'b0;
                     out_user <= 1'b0;
                     cnt      <= cnt_inc_c;
                  end
               end
               ST_DISCARD: begin
                  if (input_axis.tlast) begin
                     state <= ST_PASS;
                  end
               end
               default: state <= ST_PASS;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_axis_frame_guard.sv
// Randomized self-checking bench for axis_frame_guard with a frame-level reference model.
module tb_axis_frame_guard;
   localparam int unsigned DW      = 8;
   localparam int unsigned MAX_LEN = 4;
   localparam int unsigned MIN_LEN = 2;
   localparam int unsigned LW      = 16;

   typedef struct {
      logic [7:0] d;
      logic       last;
      logic       user;
      bit         emit;
   } beat_t;

   typedef struct {
      logic [7:0] d;
      logic       last;
      logic       user;
   } obeat_t;

   logic clk = 1'b0;
   logic rst_n;
   logic trunc_frame;

   axis_frame_guard_if #(.DATA_WIDTH(DW)) in_if ();
   axis_frame_guard_if #(.DATA_WIDTH(DW)) out_if ();

   axis_frame_guard #(
      .DATA_WIDTH (DW),
      .MAX_LEN    (MAX_LEN),
      .MIN_LEN    (MIN_LEN),
      .LEN_WIDTH  (LW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .input_axis  (in_if),
      .output_axis (out_if),
      .trunc_frame (trunc_frame)
   );

   always #5 clk = ~clk;

   int     total = 0;
   int     bad = 0;
   int     cyc = 0;
   int     exp_trunc = 0;
   int     seen_trunc = 0;
   bit     rand_mode = 1'b0;
   beat_t  stim_q[$];
   obeat_t exp_q[$];
   int     acc_cyc_q[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit runt_len(input int len);
`ifdef AXIS_FRAME_GUARD_RUNT_EN
      return len < int'(MIN_LEN);
`else
      return (len < 0);
`endif
   endfunction

   // Frame-level model: a frame longer than MAX_LEN keeps its first MAX_LEN beats, the last
   // of which is closed with tlast=1/tuser=1; the remainder never appears on the output.
   task automatic add_frame(input int len, input logic [7:0] base, input bit rnd, input logic ulast);
      beat_t  b;
      obeat_t o;
      bit     trunc;
      trunc = (len > int'(MAX_LEN));
      for (int i = 0; i < len; i++) begin
         b.d    = rnd ? 8'($urandom) : base + 8'(i);
         b.last = (i == len - 1);
         b.user = b.last ? ulast : 1'($urandom);
         b.emit = (i < int'(MAX_LEN));
         stim_q.push_back(b);
         if (b.emit) begin
            o.d    = b.d;
            o.last = b.last || (trunc && i == int'(MAX_LEN) - 1);
            o.user = trunc ? (i == int'(MAX_LEN) - 1) : (b.last && (ulast || runt_len(len)));
            exp_q.push_back(o);
         end
      end
      if (trunc) exp_trunc++;
   endtask

   task automatic run(input int budget);
      bit         in_acc;
      bit         hold_prev;
      logic [9:0] prev_out;
      obeat_t     e;
      int         lat;
      in_acc    = 1'b0;
      hold_prev = 1'b0;
      prev_out  = '0;
      while ((stim_q.size() > 0 || exp_q.size() > 0) && budget > 0) begin
         @(negedge clk);
         cyc++;
         budget--;
         if (in_acc) in_if.tvalid = 1'b0;
         out_if.tready = rand_mode ? ($urandom_range(3) != 0) : 1'b1;
         if (!in_if.tvalid && stim_q.size() > 0 && (!rand_mode || $urandom_range(3) != 0)) begin
            in_if.tvalid = 1'b1;
            in_if.tdata  = stim_q[0].d;
            in_if.tlast  = stim_q[0].last;
            in_if.tuser  = stim_q[0].user;
         end
         #1;
         if (hold_prev)
            chk("stable", 32'({out_if.tdata, out_if.tlast, out_if.tuser}), 32'(prev_out));
         if (trunc_frame) begin
            seen_trunc++;
            chk("trunc_beat", 32'({out_if.tvalid, out_if.tlast, out_if.tuser}), 32'h7);
            chk("trunc_once", 32'(hold_prev), 32'h0);
         end
         in_acc = in_if.tvalid && in_if.tready;
         if (out_if.tvalid && out_if.tready) begin
            if (exp_q.size() == 0) begin
               chk("spurious", 32'h1, 32'h0);
            end else begin
               e = exp_q.pop_front();
               chk("data", 32'(out_if.tdata), 32'(e.d));
               chk("last", 32'(out_if.tlast), 32'(e.last));
               if (e.last) chk("user", 32'(out_if.tuser), 32'(e.user));
               lat = (acc_cyc_q.size() > 0) ? cyc - acc_cyc_q.pop_front() : -1;
               if (!rand_mode) chk("latency", 32'(lat), 32'h1);
            end
         end
         if (in_acc) begin
            if (stim_q[0].emit) acc_cyc_q.push_back(cyc);
            void'(stim_q.pop_front());
         end
         hold_prev = out_if.tvalid && !out_if.tready;
         prev_out  = {out_if.tdata, out_if.tlast, out_if.tuser};
      end
      if (stim_q.size() > 0 || exp_q.size() > 0) begin
         chk("timeout", 32'h1, 32'h0);
         stim_q.delete();
         exp_q.delete();
      end
      @(negedge clk);
      in_if.tvalid = 1'b0;
      acc_cyc_q.delete();
      chk("trunc_count", 32'(seen_trunc), 32'(exp_trunc));
   endtask

   task automatic backpressure_test();
      @(negedge clk);
      out_if.tready = 1'b0;
      in_if.tvalid  = 1'b1;
      in_if.tdata   = 8'd1;
      in_if.tlast   = 1'b0;
      in_if.tuser   = 1'b0;
      #1 chk("bp_rdy_empty", 32'(in_if.tready), 32'h1);
      @(negedge clk);
      in_if.tdata = 8'd2;
      in_if.tlast = 1'b1;
      #1;
      chk("bp_valid", 32'(out_if.tvalid), 32'h1);
      chk("bp_data1", 32'(out_if.tdata), 32'h1);
      chk("bp_last1", 32'(out_if.tlast), 32'h0);
      chk("bp_rdy_full", 32'(in_if.tready), 32'h0);
      @(negedge clk);
      #1;
      chk("bp_hold_data", 32'(out_if.tdata), 32'h1);
      chk("bp_rdy_still", 32'(in_if.tready), 32'h0);
      @(negedge clk);
      out_if.tready = 1'b1;
      #1 chk("bp_rdy_release", 32'(in_if.tready), 32'h1);
      @(negedge clk);
      in_if.tvalid = 1'b0;
      #1;
      chk("bp_valid2", 32'(out_if.tvalid), 32'h1);
      chk("bp_data2", 32'(out_if.tdata), 32'h2);
      chk("bp_last2", 32'(out_if.tlast), 32'h1);
      chk("bp_user2", 32'(out_if.tuser), 32'h0);
      @(negedge clk);
      #1 chk("bp_empty", 32'(out_if.tvalid), 32'h0);
   endtask

   task automatic reset_discard_test();
      out_if.tready = 1'b1;
      for (int d = 5; d <= 9; d++) begin
         @(negedge clk);
         in_if.tvalid = 1'b1;
         in_if.tdata  = 8'(d);
         in_if.tlast  = 1'b0;
         in_if.tuser  = 1'b0;
         #1;
         if (d == 9) begin
            chk("rd_trunc_data", 32'(out_if.tdata), 32'h8);
            chk("rd_trunc_flags", 32'({out_if.tvalid, out_if.tlast, out_if.tuser}), 32'h7);
            chk("rd_trunc_pulse", 32'(trunc_frame), 32'h1);
         end
      end
      @(negedge clk);
      in_if.tvalid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("rd_reset_out", 32'({out_if.tvalid, out_if.tdata, out_if.tlast, out_if.tuser, trunc_frame}), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      in_if.tvalid = 1'b1;
      in_if.tdata  = 8'd10;
      in_if.tlast  = 1'b1;
      in_if.tuser  = 1'b0;
      #1 chk("rd_rdy", 32'(in_if.tready), 32'h1);
      @(negedge clk);
      in_if.tvalid = 1'b0;
      #1;
      chk("rd_new_valid", 32'(out_if.tvalid), 32'h1);
      chk("rd_new_data", 32'(out_if.tdata), 32'd10);
      chk("rd_new_last", 32'(out_if.tlast), 32'h1);
      chk("rd_new_user", 32'(out_if.tuser), 32'(runt_len(1)));
      @(negedge clk);
      #1 chk("rd_drained", 32'(out_if.tvalid), 32'h0);
   endtask

   initial begin
      rst_n         = 1'b0;
      in_if.tvalid  = 1'b0;
      in_if.tdata   = '0;
      in_if.tlast   = 1'b0;
      in_if.tuser   = 1'b0;
      out_if.tready = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_valid", 32'(out_if.tvalid), 32'h0);
      chk("rst_data", 32'(out_if.tdata), 32'h0);
      chk("rst_last", 32'(out_if.tlast), 32'h0);
      chk("rst_user", 32'(out_if.tuser), 32'h0);
      chk("rst_trunc", 32'(trunc_frame), 32'h0);
      chk("rst_ready", 32'(in_if.tready), 32'h1);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed frames: normal, over-long, follow-up, exactly MAX_LEN, single beat, bad input
      rand_mode = 1'b0;
      add_frame(3, 8'd1, 1'b0, 1'b0);
      add_frame(6, 8'd5, 1'b0, 1'b0);
      add_frame(2, 8'd20, 1'b0, 1'b0);
      add_frame(4, 8'd1, 1'b0, 1'b0);
      add_frame(1, 8'd7, 1'b0, 1'b0);
      add_frame(3, 8'd30, 1'b0, 1'b1);
      run(200);

      backpressure_test();

      rand_mode = 1'b1;
      for (int f = 0; f < 300; f++)
         add_frame(int'($urandom_range(1, 7)), 8'd0, 1'b1, 1'($urandom));
      run(20000);

      reset_discard_test();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
